// File: rtl/csqrt_rr_scheduler_if.sv
// Bundle of requester, core and response signals around the shared complex
// square-root core. The scheduler takes the master side.
interface csqrt_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_x;
  logic [NUM_REQ*DATA_W-1:0] req_y;

  logic                      core_start;
  logic [7:0]                core_N;
  logic [DATA_W-1:0]         core_x;
  logic [DATA_W-1:0]         core_y;
  logic [DATA_W-1:0]         core_real;
  logic [DATA_W-1:0]         core_img;
  logic                      core_valid;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_real;
  logic [DATA_W-1:0]         rsp_img;
  logic [ID_W-1:0]           rsp_id;
  logic                      rsp_err;
  logic                      busy;

  modport master (
    input  req_valid, req_x, req_y, core_real, core_img, core_valid, rsp_ready,
    output req_ready, core_start, core_N, core_x, core_y,
           rsp_valid, rsp_real, rsp_img, rsp_id, rsp_err, busy
  );

  modport slave (
    output req_valid, req_x, req_y, core_real, core_img, core_valid, rsp_ready,
    input  req_ready, core_start, core_N, core_x, core_y,
           rsp_valid, rsp_real, rsp_img, rsp_id, rsp_err, busy
  );
endinterface

// File: rtl/csqrt_rr_scheduler.sv
// Round-robin front end for one CORDIC complex square-root core: grants one
// requester, pulses start, waits for the result or a timeout, returns it tagged.
module csqrt_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ITER    = 16,
  parameter int TIMEOUT = 100,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  csqrt_rr_scheduler_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] grant_idx;
  logic            grant_any;
  logic [7:0]      timer;

  assign bus.core_N = 8'(ITER);
  assign bus.busy   = (state != IDLE);

  // Walk downward so the candidate closest to last_grant+1 is written last and wins.
  // NOTE: every always_comb output gets a default first; otherwise a path
  // that skips the assignment infers a latch.
  always_comb begin
    grant_idx = last_grant;
    grant_any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_valid[ID_W'((int'(last_grant) + k) % NUM_REQ)]) begin
        grant_idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
        grant_any = 1'b1;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && grant_any) bus.req_ready[grant_idx] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_grant     <= ID_W'(NUM_REQ - 1);
      timer          <= '0;
      bus.core_start <= 1'b0;
      bus.core_x     <= '0;
      bus.core_y     <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_real   <= '0;
      bus.rsp_img    <= '0;
      bus.rsp_id     <= '0;
      bus.rsp_err    <= 1'b0;
    end else begin
      bus.core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            bus.core_x     <= bus.req_x[int'(grant_idx) * DATA_W +: DATA_W];
            bus.core_y     <= bus.req_y[int'(grant_idx) * DATA_W +: DATA_W];
            bus.rsp_id     <= grant_idx;
            last_grant     <= grant_idx;
            bus.core_start <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 8'd1;
          // A result arriving in the last allowed cycle takes precedence over the timeout.
          if (bus.core_valid) begin
            bus.rsp_real  <= bus.core_real;
            bus.rsp_img   <= bus.core_img;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else if (timer == 8'(TIMEOUT - 1)) begin
            bus.rsp_real  <= '0;
            bus.rsp_img   <= '0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csqrt_rr_scheduler.sv
// Directed bench for csqrt_rr_scheduler with a behavioural stub core whose
// latency and returned data are set per step.
module tb_csqrt_rr_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int ITER    = 16;
  localparam int TIMEOUT = 30;
  localparam int ID_W    = 2;

  localparam logic [15:0] XS [4] = '{16'h1011, 16'h2022, 16'h3033, 16'h4044};
  localparam logic [15:0] YS [4] = '{16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03};
  localparam int GORDER [5] = '{0, 1, 2, 3, 0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csqrt_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  csqrt_rr_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ITER(ITER), .TIMEOUT(TIMEOUT), .ID_W(ID_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;

  // Stub core: answers L cycles after the start pulse (L = 0 means never).
  int          stub_lat;
  int          stub_l;
  logic        stub_echo;
  logic [15:0] stub_fr, stub_fi, stub_sx, stub_sy;
  logic        stub_valid;
  logic [15:0] stub_real, stub_img;
  logic        inj_valid;
  logic [15:0] inj_real, inj_img;

  assign bus.core_valid = stub_valid | inj_valid;
  assign bus.core_real  = inj_valid ? inj_real : stub_real;
  assign bus.core_img   = inj_valid ? inj_img  : stub_img;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.core_start === 1'b1) start_cnt++;

  always begin
    @(negedge clk);
    if (bus.core_start === 1'b1 && stub_lat != 0) begin
      stub_l  = stub_lat;
      stub_sx = bus.core_x;
      stub_sy = bus.core_y;
      repeat (stub_l) @(negedge clk);
      stub_valid = 1'b1;
      stub_real  = stub_echo ? stub_sx : stub_fr;
      stub_img   = stub_echo ? stub_sy : stub_fi;
      @(negedge clk);
      stub_valid = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 300 && bus.req_ready == '0; i++) tick();
    check("ready_seen", 32'(|bus.req_ready), 32'd1);
  endtask

  task automatic wait_rsp(output int at);
    for (int i = 0; i < 300 && bus.rsp_valid !== 1'b1; i++) tick();
    check("rsp_seen", 32'(bus.rsp_valid), 32'd1);
    at = cyc;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},      32'(bus.busy), 0);
    check({tag, "_start"},     32'(bus.core_start), 0);
    check({tag, "_core_x"},    32'(bus.core_x), 0);
    check({tag, "_core_y"},    32'(bus.core_y), 0);
    check({tag, "_core_N"},    32'(bus.core_N), 32'd16);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    check({tag, "_rsp_real"},  32'(bus.rsp_real), 0);
    check({tag, "_rsp_id"},    32'(bus.rsp_id), 0);
    check({tag, "_rsp_err"},   32'(bus.rsp_err), 0);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 0);
  endtask

  initial begin
    int t0, at, s0;
    logic [15:0] held_real;

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.rsp_ready = 1'b0;
    stub_lat = 0; stub_echo = 1'b0; stub_fr = '0; stub_fi = '0;
    stub_valid = 1'b0; stub_real = '0; stub_img = '0;
    inj_valid = 1'b0; inj_real = '0; inj_img = '0;

    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check_reset_values("reset");

    // Single request from requester 2; stub returns the known sqrt(0.75+j0.43)
    stub_lat = 5; stub_fr = 16'h7303; stub_fi = 16'h1EA2;
    tick();
    bus.req_x[2*16 +: 16] = 16'h6000;
    bus.req_y[2*16 +: 16] = 16'h370A;
    bus.req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(bus.req_ready), 32'b0100);
    t0 = cyc; s0 = start_cnt;
    tick();
    bus.req_valid = '0;
    check("single_start", 32'(bus.core_start), 1);
    check("single_core_x", 32'(bus.core_x), 32'h6000);
    check("single_core_y", 32'(bus.core_y), 32'h370A);
    check("single_busy", 32'(bus.busy), 1);
    wait_rsp(at);
    check("single_latency", at - t0, 32'd7);
    check("single_id", 32'(bus.rsp_id), 2);
    check("single_err", 32'(bus.rsp_err), 0);
    check("single_real", 32'(bus.rsp_real), 32'h7303);
    check("single_img", 32'(bus.rsp_img), 32'h1EA2);
    bus.rsp_ready = 1'b1;
    tick();
    check("single_done_valid", 32'(bus.rsp_valid), 0);
    check("single_done_busy", 32'(bus.busy), 0);
    check("single_one_start", start_cnt - s0, 1);

    // Full contention from a fresh reset: order 0,1,2,3,0 with echoed data
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    stub_lat = 20; stub_echo = 1'b1;
    bus.req_x = {XS[3], XS[2], XS[1], XS[0]};
    bus.req_y = {YS[3], YS[2], YS[1], YS[0]};
    bus.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_ready();
      check("cont_grant", 32'(bus.req_ready), 32'd1 << GORDER[k]);
      t0 = cyc; s0 = start_cnt;
      tick();
      check("cont_start", start_cnt - s0, 1);
      wait_rsp(at);
      check("cont_id", 32'(bus.rsp_id), GORDER[k]);
      check("cont_real", 32'(bus.rsp_real), 32'(XS[GORDER[k]]));
      check("cont_img", 32'(bus.rsp_img), 32'(YS[GORDER[k]]));
      check("cont_starts_per_rsp", start_cnt - s0, 1);
      if (k == 0) check("cont_latency", at - t0, 32'd22);
    end

    // Backpressure: requester 1 next; response held for 10 cycles
    tick();
    bus.rsp_ready = 1'b0;
    wait_ready();
    check("bp_grant", 32'(bus.req_ready), 32'b0010);
    wait_rsp(at);
    s0 = start_cnt;
    held_real = bus.rsp_real;
    check("bp_real", 32'(held_real), 32'(XS[1]));
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(bus.rsp_valid), 1);
      check("bp_id", 32'(bus.rsp_id), 1);
      check("bp_real_stable", 32'(bus.rsp_real), 32'(held_real));
      check("bp_img_stable", 32'(bus.rsp_img), 32'(YS[1]));
      check("bp_no_ready", 32'(bus.req_ready), 0);
      tick();
    end
    check("bp_no_start", start_cnt - s0, 0);
    bus.rsp_ready = 1'b1;
    tick();
    check("bp_released", 32'(bus.rsp_valid), 0);
    check("bp_next_grant", 32'(bus.req_ready), 32'b0100);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;

    // Timeout: stub never answers; requester 3 is next after 1
    stub_lat = 0;
    tick();
    bus.req_valid = 4'b1000;
    #1;
    check("to_grant", 32'(bus.req_ready), 32'b1000);
    t0 = cyc;
    tick();
    bus.req_valid = '0;
    wait_rsp(at);
    check("to_latency", at - t0, 32'(TIMEOUT + 2));
    check("to_err", 32'(bus.rsp_err), 1);
    check("to_real", 32'(bus.rsp_real), 0);
    check("to_img", 32'(bus.rsp_img), 0);
    check("to_id", 32'(bus.rsp_id), 3);
    inj_real = 16'h1234; inj_img = 16'h5678; inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    check("to_inj_resp_valid", 32'(bus.rsp_valid), 1);
    check("to_inj_resp_real", 32'(bus.rsp_real), 0);
    check("to_inj_resp_err", 32'(bus.rsp_err), 1);
    bus.rsp_ready = 1'b1;
    tick();
    check("to_back_idle", 32'(bus.busy), 0);
    s0 = start_cnt;
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    check("to_inj_idle_valid", 32'(bus.rsp_valid), 0);
    check("to_inj_idle_busy", 32'(bus.busy), 0);
    check("to_inj_idle_start", start_cnt - s0, 0);

    // Race: result lands in the final WAIT cycle and wins over the timeout
    stub_lat = TIMEOUT; stub_echo = 1'b0; stub_fr = 16'h0ABC; stub_fi = 16'h0DEF;
    bus.req_valid = 4'b0001;
    #1;
    check("race_grant", 32'(bus.req_ready), 32'b0001);
    t0 = cyc;
    tick();
    bus.req_valid = '0;
    wait_rsp(at);
    check("race_latency", at - t0, 32'(TIMEOUT + 2));
    check("race_err", 32'(bus.rsp_err), 0);
    check("race_real", 32'(bus.rsp_real), 32'h0ABC);
    check("race_img", 32'(bus.rsp_img), 32'h0DEF);
    check("race_id", 32'(bus.rsp_id), 0);
    tick();

    // Reset during WAIT; late core_valid must be ignored
    stub_lat = 10;
    bus.req_valid = 4'b0100;
    #1;
    check("rw_grant", 32'(bus.req_ready), 32'b0100);
    tick();
    bus.req_valid = '0;
    repeat (4) tick();
    check("rw_in_wait", 32'(bus.busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("rw");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rw_late_ignored", 32'({bus.rsp_valid, bus.busy}), 0);
    end
    bus.req_valid = 4'b1010;
    #1;
    check("rw_grant_after", 32'(bus.req_ready), 32'b0010);
    t0 = cyc;
    tick();
    bus.req_valid = '0;
    wait_rsp(at);
    check("rw_rsp_id", 32'(bus.rsp_id), 1);
    check("rw_rsp_err", 32'(bus.rsp_err), 0);
    check("rw_latency", at - t0, 32'd12);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
